// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the dump engine state encoding, reused by the trace link decoder.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Reset: n/a.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

    function automatic logic is_active(input dump_state_t st);
        return (st == FETCH) || (st == SEND);
    endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Streams {addr, data} beats of every architectural register, read through an async rf port.
// Latency: start -> first beat valid in 2 cycles; 2 cycles per beat when the sink never stalls.
// Backpressure: a beat is held stable in SEND until out_ready; abort/rst are the only ways to drop it.
module regfile_dump_reader
    import riscv_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter bit SKIP_X0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_X0 ? ADDR_W'(1) : ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] beat_addr_q;
    logic [DATA_W-1:0] beat_data_q;
    logic              beat_last_q;
    logic              beat_load;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        beat_load = 1'b0;
        case (state_q)
            IDLE: begin
                // start wins over a simultaneous abort
                if (start) begin
                    idx_d   = FIRST_IDX;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    beat_load = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (beat_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            beat_addr_q <= '0;
            beat_data_q <= '0;
            beat_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            // the register is sampled in its FETCH cycle, so earlier core writes are visible
            if (beat_load) begin
                beat_addr_q <= idx_q;
                beat_data_q <= rd_data;
                beat_last_q <= (idx_q == LAST_IDX);
            end
        end
    end

    assign rd_addr   = idx_q;
    assign busy      = is_active(state_q);
    assign done      = (state_q == DONE);
    assign out_valid = (state_q == SEND);
    assign out_addr  = beat_addr_q;
    assign out_data  = beat_data_q;
    assign out_last  = beat_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: two engines (x0 scanned / x0 skipped) on one behavioural register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready, sel;
    logic [31:0] regs [32];

    logic        busy_a, done_a, valid_a, last_a;
    logic [4:0]  rd_addr_a, addr_a;
    logic [31:0] data_a;
    logic        busy_b, done_b, valid_b, last_b;
    logic [4:0]  rd_addr_b, addr_b;
    logic [31:0] data_b;

    logic        m_busy, m_done, m_valid, m_last;
    logic [4:0]  m_rd_addr, m_addr;
    logic [31:0] m_data;

    int compared   = 0;
    int mismatched = 0;
    int wcyc1 = -1, wcyc2 = -1;
    int waddr1, waddr2;
    logic [31:0] wdat1, wdat2;
    bit ovr20 = 1'b0;

    always #5 clk = ~clk;

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort),
        .busy(busy_a), .done(done_a), .rd_addr(rd_addr_a), .rd_data(regs[rd_addr_a]),
        .out_valid(valid_a), .out_ready(out_ready), .out_addr(addr_a),
        .out_data(data_a), .out_last(last_a)
    );

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort),
        .busy(busy_b), .done(done_b), .rd_addr(rd_addr_b), .rd_data(regs[rd_addr_b]),
        .out_valid(valid_b), .out_ready(out_ready), .out_addr(addr_b),
        .out_data(data_b), .out_last(last_b)
    );

    always_comb begin
        m_busy    = sel ? busy_b    : busy_a;
        m_done    = sel ? done_b    : done_a;
        m_valid   = sel ? valid_b   : valid_a;
        m_last    = sel ? last_b    : last_a;
        m_rd_addr = sel ? rd_addr_b : rd_addr_a;
        m_addr    = sel ? addr_b    : addr_a;
        m_data    = sel ? data_b    : data_a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a);
        if (a == 0) return 32'h0;
        if (ovr20 && a == 20) return 32'hBABA_BABA;
        return 32'h1000_0000 + a;
    endfunction

    // rmode 0: ready always high; 1: ready follows a 0,0,1 pattern.
    // stop_addr >= 0: return during the SEND cycle of that address without accepting it.
    // inj_addr >= 0: pulse start while that beat is being offered.
    task automatic dump(input bit s, input int rmode, input int stop_addr, input int inj_addr,
                        output int nbeats, output int done_cyc);
        int          cyc;
        int          exp_a;
        bit          held;
        logic [4:0]  h_a;
        logic [31:0] h_d;
        logic        h_l;
        sel      = s;
        nbeats   = 0;
        done_cyc = -1;
        exp_a    = s ? 1 : 0;
        held     = 1'b0;
        h_a = '0; h_d = '0; h_l = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400 && done_cyc < 0) begin
            if (cyc == wcyc1) regs[waddr1] = wdat1;
            if (cyc == wcyc2) regs[waddr2] = wdat2;
            out_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 2);
            start = (inj_addr >= 0) && m_valid && (m_addr == 5'(inj_addr));
            if (cyc == 1) begin
                check("busy_in_fetch", 64'(m_busy), 64'd1);
                check("valid_in_fetch", 64'(m_valid), 64'd0);
            end
            if (held) begin
                check("held_valid", 64'(m_valid), 64'd1);
                check("held_addr", 64'(m_addr), 64'(h_a));
                check("held_data", 64'(m_data), 64'(h_d));
                check("held_last", 64'(m_last), 64'(h_l));
            end
            if (stop_addr >= 0 && m_valid && m_addr == 5'(stop_addr)) begin
                start = 1'b0;
                return;
            end
            if (m_valid && out_ready) begin
                check("beat_addr", 64'(m_addr), 64'(exp_a));
                check("beat_data", 64'(m_data), 64'(exp_data(exp_a)));
                check("beat_last", 64'(m_last), 64'(exp_a == 31));
                nbeats++;
                exp_a++;
            end
            held = m_valid && !out_ready;
            h_a  = m_addr;
            h_d  = m_data;
            h_l  = m_last;
            if (m_done) done_cyc = cyc;
            tick();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int nb, dc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; sel = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        tick();
        tick();
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_last", 64'(last_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_data", 64'(data_a), 64'd0);
        check("rst_rd_addr", 64'(rd_addr_a), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 64'(busy_a), 64'd0);

        // full dump, ready tied high
        dump(1'b0, 0, -1, -1, nb, dc);
        check("full_beats", 64'(nb), 64'd32);
        check("full_done_cycle", 64'(dc), 64'd65);
        check("full_idle_busy", 64'(m_busy), 64'd0);
        check("full_idle_done", 64'(m_done), 64'd0);
        check("full_idle_valid", 64'(m_valid), 64'd0);

        // x0 skipped
        dump(1'b1, 0, -1, -1, nb, dc);
        check("skip_beats", 64'(nb), 64'd31);
        check("skip_done_cycle", 64'(dc), 64'd63);
        check("skip_idle_busy", 64'(m_busy), 64'd0);

        // stalling sink
        dump(1'b0, 1, -1, -1, nb, dc);
        check("stall_beats", 64'(nb), 64'd32);
        check("stall_done_seen", 64'(dc > 0), 64'd1);

        // abort while x7 is offered (and ready high in that same cycle)
        dump(1'b0, 0, 7, -1, nb, dc);
        check("abort_pre_beats", 64'(nb), 64'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_valid", 64'(m_valid), 64'd0);
        check("abort_busy", 64'(m_busy), 64'd0);
        check("abort_done", 64'(m_done), 64'd0);
        tick();
        check("abort_done_later", 64'(m_done), 64'd0);
        check("abort_busy_later", 64'(m_busy), 64'd0);
        dump(1'b0, 0, -1, -1, nb, dc);
        check("restart_beats", 64'(nb), 64'd32);
        check("restart_done_cycle", 64'(dc), 64'd65);

        // start while busy is ignored, then rst while x12 is offered
        dump(1'b0, 0, 12, 5, nb, dc);
        check("rst_pre_beats", 64'(nb), 64'd12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_busy", 64'(m_busy), 64'd0);
        check("mid_rst_done", 64'(m_done), 64'd0);
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_last", 64'(m_last), 64'd0);
        check("mid_rst_addr", 64'(m_addr), 64'd0);
        check("mid_rst_data", 64'(m_data), 64'd0);
        check("mid_rst_rd_addr", 64'(m_rd_addr), 64'd0);

        // core writes during the dump: x20 before its fetch, x3 after
        wcyc1 = 10; waddr1 = 20; wdat1 = 32'hBABA_BABA;
        wcyc2 = 30; waddr2 = 3;  wdat2 = 32'hBABA_BABA;
        ovr20 = 1'b1;
        dump(1'b0, 0, -1, -1, nb, dc);
        check("write_beats", 64'(nb), 64'd32);
        check("write_done_cycle", 64'(dc), 64'd65);
        wcyc1 = -1; wcyc2 = -1; ovr20 = 1'b0;
        regs[20] = 32'h1000_0014;
        regs[3]  = 32'h1000_0003;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
